// File: rtl/fsub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package fsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fsub1.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when that underflows.
module fsub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/fsub_serial.sv
// Bit-serial subtractor: r = a - b, one bit per clock, LSB first,
// built around a single fsub1 cell.
//
// Handshake: start is sampled on a rising edge while the block is in IDLE or
// DONE; that edge captures a and b. busy is high for the WIDTH cycles in which
// bits are computed, and start is ignored while busy. done pulses for exactly
// one cycle, in which r/borrow/overflow already carry the new result; those
// outputs then hold until the next done.
module fsub_serial
    import fsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // FSM state is kept in a plainly named register so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic             load;
    logic             shift;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             bin;
    logic             sa;
    logic             sb;

    logic             d;
    logic             bout;

    fsub1 u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; DONE accepts start just like IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Operand/result shift registers, borrow chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            sa   <= a[WIDTH-1];
            sb   <= b[WIDTH-1];
            bin  <= 1'b0;
            cnt  <= '0;
        end else if (shift) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d, res_sr[WIDTH-1:1]};
            bin    <= bout;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the edge that computes the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (last) begin
            r        <= {d, res_sr[WIDTH-1:1]};
            borrow   <= bout;
            overflow <= (sa != sb) && (d != sa);
        end
    end

endmodule

// File: tb/tb_fsub_serial.sv
// Self-checking bench for fsub_serial: directed protocol cases plus random
// operands compared against an integer-arithmetic reference.
module tb_fsub_serial;

    localparam int W = 4;
    localparam int MOD = 2 ** W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         borrow;
    logic         overflow;

    int           total;
    int           bad;
    logic [W-1:0] last_r;

    fsub_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .r        (r),
        .borrow   (borrow),
        .overflow (overflow)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer subtraction.
    task automatic model(input int av, input int bv,
                         output logic [W-1:0] er, output logic eb, output logic eo);
        int sa, sb, diff;
        er = W'((av - bv + MOD) % MOD);
        eb = (av < bv);
        sa = (av >= MOD / 2) ? av - MOD : av;
        sb = (bv >= MOD / 2) ? bv - MOD : bv;
        diff = sa - sb;
        eo = (diff > MOD / 2 - 1) || (diff < -(MOD / 2));
    endtask

    // Present operands and start in the cycle before an edge, then release.
    task automatic start_op(input int av, input int bv);
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom_range(0, MOD - 1));
        b = W'($urandom_range(0, MOD - 1));
    endtask

    // Wait (bounded) for done after an accepted start and check the result.
    // mode 1: pulse start with a=1,b=1 mid-run. mode 2: hold start with
    // a=6,b=2 in the done cycle and return without releasing it.
    task automatic wait_done(input int av, input int bv, input int mode, input string tag);
        int cycles;
        int busy_n;
        logic seen;
        logic [W-1:0] er;
        logic eb, eo;
        model(av, bv, er, eb, eo);
        cycles = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) chk({tag, "_r_hold"}, 32'(r), 32'(last_r));
            if (mode == 1 && cycles == 2) begin
                start = 1'b1;
                a = W'(1);
                b = W'(1);
            end
            if (mode == 1 && cycles == 3) start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cycles), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
        last_r = er;
        if (mode == 2) begin
            start = 1'b1;
            a = W'(6);
            b = W'(2);
        end else begin
            @(negedge clk);
            chk({tag, "_done_low"}, 32'(done), 32'd0);
            chk({tag, "_r_held"}, 32'(r), 32'(er));
        end
    endtask

    initial begin
        int av, bv;
        logic saw_done;
        total  = 0;
        bad    = 0;
        last_r = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic.
        start_op(5, 3);  wait_done(5, 3, 0, "d5_3");
        start_op(3, 4);  wait_done(3, 4, 0, "d3_4");
        start_op(0, 0);  wait_done(0, 0, 0, "d0_0");
        start_op(8, 1);  wait_done(8, 1, 0, "d8_1");
        start_op(7, 15); wait_done(7, 15, 0, "d7_15");

        // start during RUN is ignored.
        start_op(5, 3);  wait_done(5, 3, 1, "midrun");

        // Back-to-back: start held in the done cycle.
        start_op(5, 3);  wait_done(5, 3, 2, "chain1");
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, 2, 0, "chain2");

        // Asynchronous reset between edges aborts the operation.
        start_op(13, 2);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_r", 32'(r), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_r = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        start_op(9, 4);  wait_done(9, 4, 0, "after_abort");

        // Random operands.
        for (int i = 0; i < 30; i++) begin
            av = $urandom_range(0, MOD - 1);
            bv = $urandom_range(0, MOD - 1);
            start_op(av, bv);
            wait_done(av, bv, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsub_serial.md
Name: fsub_serial

Overview:
- Bit-serial subtractor: the inverse companion to the combinational ripple adder in the arithmetic exercises.
- Computes r = a - b over WIDTH cycles, one bit per clock, LSB first, using a single full-subtractor cell.
- Uses a start/busy/done handshake and a held result.
- Sits beside the combinational adder as the area-minimal arithmetic option for sequential datapaths.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled on the rising edge.
- a  input  WIDTH  minuend; sampled only when start is accepted.
- b  input  WIDTH  subtrahend; sampled only when start is accepted.
- busy  output  1  high while bits are being computed.
- done  output  1  single-cycle pulse when r, borrow and overflow become valid.
- r  output  WIDTH  difference a - b mod 2^WIDTH; held until the next result.
- borrow  output  1  unsigned borrow out; 1 iff a < b unsigned.
- overflow  output  1  two's-complement overflow of a - b.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state to IDLE;
  - busy, done, r, borrow, overflow to 0;
  - internal shift registers, bit counter and borrow chain to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at an edge: latch a and b into shift registers, latch sign bits a[WIDTH-1] and b[WIDTH-1], clear borrow chain to 0, clear counter to 0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Bit cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), where a0 and b0 are the shift-register LSBs.
  - d shifts into the MSB of the result shift register; both operand registers shift right; bin <= bout; counter increments.
  - After the WIDTH-th bit edge (counter reaches WIDTH-1 and shifts), go to DONE.
- Entering DONE (same edge as the last bit):
  - r <= assembled result; borrow <= final bout.
  - overflow <= (sa != sb) && (r_msb != sa), where sa and sb are the latched sign bits.
  - busy=0; done=1 for exactly one cycle.
- DONE:
  - Returns to IDLE on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- Latency: start accepted at edge E0; busy high during cycles E0..E(WIDTH); done high in the cycle after edge E(WIDTH). That is WIDTH+1 edges from start to the done cycle.
- start while busy (RUN) is ignored; a and b may change freely during RUN with no effect.
- r, borrow and overflow hold their last values in IDLE and RUN; they change only on entry to DONE.
- Reset mid-operation aborts immediately; no done pulse; outputs are zeroed.
- Arithmetic is mod 2^WIDTH, with no saturation.

Decomposition:
- Package fsub_pkg:
  - typedef enum state_t {IDLE, RUN, DONE};
  - localparam DEFAULT_WIDTH = 4.
- Sub-module fsub1: a purely combinational 1-bit full subtractor with inputs a, b, bin and outputs d, bout, instantiated once.
- The top level holds the FSM, shift registers, counter (width $clog2(WIDTH)+1) and output registers.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> r=0, busy=0, done=0, borrow=0, overflow=0.
- a=5, b=3, start 1 cycle -> busy high 4 cycles, done pulse on the 5th edge cycle; r=2, borrow=0, overflow=0; done low the next cycle.
- a=3, b=4 -> r=4'hF, borrow=1, overflow=0. Then a=0, b=0 -> r=0, borrow=0, overflow=0.
- Signed overflow:
  - a=8 (-8), b=1 -> r=7, borrow=0, overflow=1.
  - a=7, b=15 (-1) -> r=8, borrow=1, overflow=1.
- Protocol:
  - start pulsed again mid-RUN with a=1, b=1 -> ignored; first result (5-3=2) reported.
  - start held high in the DONE cycle with a=6, b=2 -> second op accepted; r=4 after a further WIDTH+1 edges.
- rst_n asserted asynchronously mid-RUN (between edges) -> busy and r drop to 0 immediately; no done pulse; next start with a=9, b=4 gives r=5 normally.
